// File: rtl/fetch_ctrl_if.sv
// Bundle of fetch-controller control, status and instruction-ROM signals.
// master = sequencer/testbench side, slave = fetch_ctrl.
interface fetch_ctrl_if #(
  parameter int A = 10,
  parameter int W = 9
);
  logic          start;
  logic [A-1:0]  start_addr;
  logic          stall;
  logic          branch_taken;
  logic [A-1:0]  branch_target;
  logic          halt;
  logic [A-1:0]  instr_address;
  logic [W-1:0]  instr_in;
  logic [W-1:0]  instr_out;
  logic          instr_valid;
  logic          done;
  logic          err;
  logic [15:0]   retired;

  modport master (
    output start, start_addr, stall, branch_taken, branch_target, halt, instr_in,
    input  instr_address, instr_out, instr_valid, done, err, retired
  );

  modport slave (
    input  start, start_addr, stall, branch_taken, branch_target, halt, instr_in,
    output instr_address, instr_out, instr_valid, done, err, retired
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: IDLE/RUN/HALT with branch, stall, halt,
// PC-overflow detection and a saturating retired-instruction counter.
module fetch_ctrl #(
  parameter int A = 10,
  parameter int W = 9
) (
  input  logic clk,
  input  logic rst_n,
  fetch_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [A-1:0] PC_MAX = {A{1'b1}};

  state_t        r_state, w_state_next;
  logic [A-1:0]  r_pc, w_pc_next;
  logic [15:0]   r_retired, w_retired_next;
  logic          r_err, w_err_next;
  logic [15:0]   w_retired_inc;

  assign w_retired_inc = (r_retired == 16'hFFFF) ? r_retired : r_retired + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_retired <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_retired <= w_retired_next;
      r_err     <= w_err_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_retired_next = r_retired;
    w_err_next     = r_err;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          w_state_next   = S_RUN;
          w_pc_next      = bus.start_addr;
          w_retired_next = '0;
          w_err_next     = 1'b0;
        end
      end
      S_RUN: begin
        // Halt and branch both retire the current instruction regardless of stall.
        if (bus.halt) begin
          w_state_next   = S_HALT;
          w_retired_next = w_retired_inc;
        end else if (bus.branch_taken) begin
          w_pc_next      = bus.branch_target;
          w_retired_next = w_retired_inc;
        end else if (bus.stall) begin
          w_pc_next      = r_pc;
        end else if (r_pc == PC_MAX) begin
          w_state_next   = S_HALT;
          w_err_next     = 1'b1;
          w_retired_next = w_retired_inc;
        end else begin
          w_pc_next      = r_pc + 1'b1;
          w_retired_next = w_retired_inc;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.instr_address = r_pc;
  assign bus.instr_valid   = (r_state == S_RUN);
  assign bus.instr_out     = (r_state == S_RUN) ? bus.instr_in : '0;
  assign bus.done          = (r_state == S_HALT);
  assign bus.err           = r_err;
  assign bus.retired       = r_retired;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a 10-bit-address instance for the main
// sequences and a 4-bit-address instance for PC overflow.
module tb_fetch_ctrl;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  fetch_ctrl_if #(.A(10), .W(9)) b10 ();
  fetch_ctrl_if #(.A(4),  .W(9)) b4 ();

  fetch_ctrl #(.A(10), .W(9)) u10 (.clk(clk), .rst_n(rst_n), .bus(b10));
  fetch_ctrl #(.A(4),  .W(9)) u4  (.clk(clk), .rst_n(rst_n), .bus(b4));

  // ROM contents: address XOR a constant pattern
  assign b10.instr_in = b10.instr_address[8:0] ^ 9'h0A5;
  assign b4.instr_in  = {5'd0, b4.instr_address} ^ 9'h0A5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk10(input string tag, input logic [9:0] pc, input logic v,
                       input logic d, input logic e, input logic [15:0] ret);
    logic [8:0] exp_instr;
    exp_instr = v ? (pc[8:0] ^ 9'h0A5) : 9'd0;
    check({tag, ".pc"},      32'(b10.instr_address), 32'(pc));
    check({tag, ".valid"},   32'(b10.instr_valid),   32'(v));
    check({tag, ".instr"},   32'(b10.instr_out),     32'(exp_instr));
    check({tag, ".done"},    32'(b10.done),          32'(d));
    check({tag, ".err"},     32'(b10.err),           32'(e));
    check({tag, ".retired"}, 32'(b10.retired),       32'(ret));
    $display("step %-10s pc=%0d valid=%0b done=%0b err=%0b retired=%0d",
             tag, b10.instr_address, b10.instr_valid, b10.done, b10.err, b10.retired);
  endtask

  task automatic chk4(input string tag, input logic [3:0] pc, input logic v,
                      input logic d, input logic e, input logic [15:0] ret);
    check({tag, ".pc"},      32'(b4.instr_address), 32'(pc));
    check({tag, ".valid"},   32'(b4.instr_valid),   32'(v));
    check({tag, ".done"},    32'(b4.done),          32'(d));
    check({tag, ".err"},     32'(b4.err),           32'(e));
    check({tag, ".retired"}, 32'(b4.retired),       32'(ret));
    $display("step %-10s pc=%0d valid=%0b done=%0b err=%0b retired=%0d",
             tag, b4.instr_address, b4.instr_valid, b4.done, b4.err, b4.retired);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    b10.start = 0; b10.start_addr = '0; b10.stall = 0;
    b10.branch_taken = 0; b10.branch_target = '0; b10.halt = 0;
    b4.start = 0; b4.start_addr = '0; b4.stall = 0;
    b4.branch_taken = 0; b4.branch_target = '0; b4.halt = 0;

    #2;
    chk10("reset", 10'd0, 0, 0, 0, 16'd0);
    chk4("reset4", 4'd0, 0, 0, 0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk10("idle", 10'd0, 0, 0, 0, 16'd0);

    // Start at 5 and free-run
    b10.start = 1; b10.start_addr = 10'd5;
    tick();
    b10.start = 0;
    chk10("run5", 10'd5, 1, 0, 0, 16'd0);
    tick();
    chk10("run6", 10'd6, 1, 0, 0, 16'd1);
    tick();
    chk10("run7", 10'd7, 1, 0, 0, 16'd2);
    // start while running must be ignored
    b10.start = 1; b10.start_addr = 10'd2;
    tick();
    b10.start = 0;
    chk10("run8", 10'd8, 1, 0, 0, 16'd3);
    tick();
    chk10("run9", 10'd9, 1, 0, 0, 16'd4);

    // Asynchronous reset pulse between edges; start during release honoured
    #1 rst_n = 1'b0;
    #1 chk10("async_rst", 10'd0, 0, 0, 0, 16'd0);
    #1 rst_n = 1'b1;
    b10.start = 1; b10.start_addr = 10'd10;
    tick();
    b10.start = 0;
    chk10("run10", 10'd10, 1, 0, 0, 16'd0);

    // Stall twice, then branch with stall
    b10.stall = 1;
    tick();
    chk10("stall1", 10'd10, 1, 0, 0, 16'd0);
    tick();
    chk10("stall2", 10'd10, 1, 0, 0, 16'd0);
    b10.branch_taken = 1; b10.branch_target = 10'd3;
    tick();
    chk10("br3", 10'd3, 1, 0, 0, 16'd1);
    b10.stall = 0; b10.branch_target = 10'd20;
    tick();
    chk10("br20", 10'd20, 1, 0, 0, 16'd2);

    // halt beats branch
    b10.halt = 1; b10.branch_target = 10'd3;
    tick();
    b10.halt = 0; b10.branch_taken = 0;
    chk10("halt20", 10'd20, 0, 1, 0, 16'd3);
    tick();
    chk10("hold20", 10'd20, 0, 1, 0, 16'd3);
    b10.start = 1; b10.start_addr = 10'd0;
    tick();
    b10.start = 0;
    chk10("restart0", 10'd0, 1, 0, 0, 16'd0);

    // Branch to the top address is legal; the following increment overflows
    b10.branch_taken = 1; b10.branch_target = 10'd1023;
    tick();
    b10.branch_taken = 0;
    chk10("br1023", 10'd1023, 1, 0, 0, 16'd1);
    tick();
    chk10("ovf10", 10'd1023, 0, 1, 1, 16'd2);

    // Restart clears err; halt with stall still retires
    b10.start = 1; b10.start_addr = 10'd100;
    tick();
    b10.start = 0;
    chk10("run100", 10'd100, 1, 0, 0, 16'd0);
    b10.halt = 1; b10.stall = 1;
    tick();
    b10.halt = 0; b10.stall = 0;
    chk10("haltstl", 10'd100, 0, 1, 0, 16'd1);

    // Overflow on the 4-bit instance
    b4.start = 1; b4.start_addr = 4'd14;
    tick();
    b4.start = 0;
    chk4("a4_pc14", 4'd14, 1, 0, 0, 16'd0);
    tick();
    chk4("a4_pc15", 4'd15, 1, 0, 0, 16'd1);
    tick();
    chk4("a4_ovf", 4'd15, 0, 1, 1, 16'd2);

    // Retired saturation via a one-instruction branch loop at address 0
    b10.start = 1; b10.start_addr = 10'd0;
    tick();
    b10.start = 0;
    b10.branch_taken = 1; b10.branch_target = 10'd0;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk10("sat_fffe", 10'd0, 1, 0, 0, 16'hFFFE);
    tick();
    chk10("sat_ffff", 10'd0, 1, 0, 0, 16'hFFFF);
    repeat (5) tick();
    chk10("sat_hold", 10'd0, 1, 0, 0, 16'hFFFF);
    b10.branch_taken = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter A, default 10, instruction address width; SHALL size the PC and every address port.
REQ-002 Parameter W, default 9, instruction word width; SHALL size the instruction ports.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin execution at start_addr.
REQ-006 start_addr  input  A  first PC value loaded by start.
REQ-007 stall  input  1  hold PC and suppress retire count this cycle.
REQ-008 branch_taken  input  1  load PC from branch_target next cycle.
REQ-009 branch_target  input  A  absolute branch destination.
REQ-010 halt  input  1  current instruction is the final instruction; stop after it.
REQ-011 instr_address  output  A  registered PC, drives the instruction ROM address.
REQ-012 instr_in  input  W  combinational ROM data for instr_address.
REQ-013 instr_out  output  W  instruction to decode.
REQ-014 instr_valid  output  1  instr_out is a live instruction.
REQ-015 done  output  1  program finished (normal halt or PC overflow).
REQ-016 err  output  1  sticky flag, PC overflow occurred.
REQ-017 retired  output  16  retired-instruction count.

Function
REQ-018 States IDLE, RUN, HALT; encoding free.
REQ-019 IDLE: start=1 -> PC<=start_addr, retired<=0, err<=0, go to RUN; otherwise hold.
REQ-020 RUN: instr_valid=1, instr_out=instr_in, both combinational from current PC.
REQ-021 Outside RUN: instr_valid=0, instr_out=0.
REQ-022 RUN PC next-value priority: halt > branch_taken > stall > PC+1.
REQ-023 halt=1 in RUN: go to HALT, PC held, instruction counts as retired even if stall=1.
REQ-024 branch_taken=1 (no halt): PC<=branch_target, retired+1, stall ignored that cycle.
REQ-025 stall=1 (no halt, no branch): PC and retired hold; instruction re-presented next cycle.
REQ-026 Otherwise PC<=PC+1 and retired+1.
REQ-027 Overflow: increment with PC=2**A-1 -> go to HALT, err<=1, PC held at 2**A-1; instruction counts as retired; no wrap to 0.
REQ-028 Branch to any address, including 2**A-1, is legal and SHALL NOT set err.
REQ-029 retired SHALL saturate at 16'hFFFF.
REQ-030 start asserted in RUN SHALL be ignored.
REQ-031 HALT: done=1, PC/retired/err hold; start=1 -> same action as REQ-019 (restart).
REQ-032 done=0 in IDLE and RUN.
REQ-033 Latency: start at edge N -> instr_valid=1 with instr_address=start_addr in cycle N+1.

Reset
REQ-034 rst_n=0 SHALL immediately, independent of clk, force state IDLE, PC=0, retired=0, err=0, done=0, instr_valid=0, instr_out=0.
REQ-035 Reset mid-RUN SHALL abort without completing the current instruction; no retire.
REQ-036 After rst_n rises, block stays in IDLE until start; start in the release cycle is honoured at the next edge.

Verification
REQ-037 Reset, start with start_addr=5, no stall/branch for 4 cycles -> instr_address 5,6,7,8; retired=4; instr_valid high from first cycle after start.
REQ-038 RUN at PC=10, stall=1 for 2 cycles then branch_taken=1 with target=3 and stall=1 -> PC 10,10,10,3; retired increments by 1 only on branch cycle.
REQ-039 RUN at PC=20, halt=1 and branch_taken=1 together -> HALT, PC=20, done=1, err=0, instr_valid=0; start with start_addr=0 -> RUN at PC=0, retired=0.
REQ-040 A=4, start_addr=14 -> PC 14,15 then HALT with err=1, done=1, PC=15, retired=2.
REQ-041 rst_n pulsed low between clock edges while in RUN at PC=9 -> outputs reach reset values before next edge; start ignored in RUN checked beforehand (start at PC=7 leaves PC advancing to 8).
REQ-042 Retired count preloaded near limit via long run (>=65536 unstalled cycles with branch loop) -> retired holds at 16'hFFFF.
